bmem_line_arbiter: RTL and testbench

//  Shares one burst-memory port between two line requesters: port 0 (I-side, read-only) and port 1 (D-side, read/write).

---
 rtl/bmem_line_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_bmem_line_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_line_arbiter.sv
// bmem_line_arbiter: shares one burst-memory port between an I-side line reader
// (port 0) and a D-side line reader/writer (port 1). Read bursts are assembled
// into full lines, write lines are sliced into beats, and the winner gets a
// one-cycle completion pulse carrying the line.
module bmem_line_arbiter #(
  parameter int unsigned BUS_WIDTH  = 64,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RR_EN      = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_read,
  input  logic [ADDR_WIDTH-1:0]            i_addr,
  output logic [BUS_WIDTH*BURST_LEN-1:0]   i_rdata,
  output logic                             i_resp,
  input  logic                             d_read,
  input  logic                             d_write,
  input  logic [ADDR_WIDTH-1:0]            d_addr,
  input  logic [BUS_WIDTH*BURST_LEN-1:0]   d_wdata,
  output logic [BUS_WIDTH*BURST_LEN-1:0]   d_rdata,
  output logic                             d_resp,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [BUS_WIDTH-1:0]             mem_wdata,
  input  logic [BUS_WIDTH-1:0]             mem_rdata,
  input  logic                             mem_resp
);

  localparam int unsigned LINE_WIDTH = BUS_WIDTH * BURST_LEN;
  localparam int unsigned OFS_W      = $clog2(LINE_WIDTH / 8);
  localparam int unsigned CNT_W      = $clog2(BURST_LEN + 1);
  localparam int unsigned IDX_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << OFS_W) - ADDR_WIDTH'(1));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            r_state,     w_nxt_state;
  logic [CNT_W-1:0]      r_cnt,       w_nxt_cnt;
  logic                  r_gnt_d,     w_nxt_gnt_d;
  logic                  r_pref_d,    w_nxt_pref_d;
  logic                  r_was_wr,    w_nxt_was_wr;
  logic                  r_mem_read,  w_nxt_mem_read;
  logic                  r_mem_write, w_nxt_mem_write;
  logic                  r_i_resp,    w_nxt_i_resp;
  logic                  r_d_resp,    w_nxt_d_resp;
  logic [ADDR_WIDTH-1:0] r_addr,      w_nxt_addr;
  logic [LINE_WIDTH-1:0] r_line,      w_nxt_line;

  logic                  w_req_i;
  logic                  w_req_d;
  logic                  w_pick_d;
  logic                  w_last;
  logic [IDX_W-1:0]      w_idx;
  logic [ADDR_WIDTH-1:0] w_sel_addr;

  // Arbitration decision: D wins when alone, under fixed priority, or when it is its turn
  assign w_req_i    = i_read;
  assign w_req_d    = d_read | d_write;
  assign w_pick_d   = w_req_d && (!w_req_i || (RR_EN == 0) || r_pref_d);
  assign w_sel_addr = w_pick_d ? d_addr : i_addr;
  assign w_idx      = IDX_W'(r_cnt);
  assign w_last     = (r_cnt == LAST_CNT);

  // Next-state and next-output logic for the transaction sequencer
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_cnt;
    w_nxt_gnt_d     = r_gnt_d;
    w_nxt_pref_d    = r_pref_d;
    w_nxt_was_wr    = r_was_wr;
    w_nxt_mem_read  = r_mem_read;
    w_nxt_mem_write = r_mem_write;
    w_nxt_i_resp    = 1'b0;
    w_nxt_d_resp    = 1'b0;
    w_nxt_addr      = r_addr;
    w_nxt_line      = r_line;

    case (r_state)
      S_IDLE: begin
        if (w_req_i || w_req_d) begin
          w_nxt_gnt_d  = w_pick_d;
          w_nxt_pref_d = !w_pick_d;
          w_nxt_addr   = w_sel_addr & ALIGN_MASK;
          w_nxt_cnt    = '0;
          if (w_pick_d && d_write) begin
            w_nxt_state     = S_WRITE;
            w_nxt_mem_write = 1'b1;
            w_nxt_was_wr    = 1'b1;
          end else begin
            w_nxt_state    = S_READ;
            w_nxt_mem_read = 1'b1;
            w_nxt_was_wr   = 1'b0;
          end
        end
      end
      S_READ: begin
        if (mem_resp) begin
          w_nxt_line[w_idx*BUS_WIDTH +: BUS_WIDTH] = mem_rdata;
          w_nxt_cnt = r_cnt + CNT_W'(1);
          if (w_last) begin
            w_nxt_mem_read = 1'b0;
            w_nxt_state    = S_DONE;
            w_nxt_i_resp   = !r_gnt_d;
            w_nxt_d_resp   = r_gnt_d;
          end
        end
      end
      S_WRITE: begin
        if (mem_resp) begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
          if (w_last) begin
            w_nxt_mem_write = 1'b0;
            w_nxt_state     = S_DONE;
            w_nxt_i_resp    = !r_gnt_d;
            w_nxt_d_resp    = r_gnt_d;
          end
        end
      end
      S_DONE: begin
        w_nxt_cnt   = '0;
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state     = S_IDLE;
        w_nxt_mem_read  = 1'b0;
        w_nxt_mem_write = 1'b0;
        w_nxt_cnt       = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight burst
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_gnt_d     <= 1'b0;
      r_pref_d    <= 1'b1;
      r_was_wr    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_i_resp    <= 1'b0;
      r_d_resp    <= 1'b0;
      r_addr      <= '0;
      r_line      <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_gnt_d     <= w_nxt_gnt_d;
      r_pref_d    <= w_nxt_pref_d;
      r_was_wr    <= w_nxt_was_wr;
      r_mem_read  <= w_nxt_mem_read;
      r_mem_write <= w_nxt_mem_write;
      r_i_resp    <= w_nxt_i_resp;
      r_d_resp    <= w_nxt_d_resp;
      r_addr      <= w_nxt_addr;
      r_line      <= w_nxt_line;
    end
  end

  // Output decode: line data only appears alongside its own completion pulse
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_addr;
  assign i_resp    = r_i_resp;
  assign d_resp    = r_d_resp;
  assign i_rdata   = r_i_resp ? r_line : '0;
  assign d_rdata   = (r_d_resp && !r_was_wr) ? r_line : '0;
  assign mem_wdata = (r_state == S_WRITE) ? d_wdata[w_idx*BUS_WIDTH +: BUS_WIDTH] : '0;

  // Protocol checks: D-side must not read and write at once; no beats outside a burst
  a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst)
    !(d_read && d_write));
  a_stray_resp: assert property (@(posedge clk) disable iff (!rst)
    !(mem_resp && ((r_state == S_IDLE) || (r_state == S_DONE))));

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Bench for bmem_line_arbiter: two instances (round-robin and fixed priority)
// driven by a cycle-stepped requester/memory environment and compared every
// cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_bmem_line_arbiter;

  localparam int unsigned BW = 64;
  localparam int unsigned BL = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = BW * BL;
  localparam int unsigned NI = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          i_read_s   [NI];
  logic [AW-1:0] i_addr_s   [NI];
  logic [LW-1:0] i_rdata_s  [NI];
  logic          i_resp_s   [NI];
  logic          d_read_s   [NI];
  logic          d_write_s  [NI];
  logic [AW-1:0] d_addr_s   [NI];
  logic [LW-1:0] d_wdata_s  [NI];
  logic [LW-1:0] d_rdata_s  [NI];
  logic          d_resp_s   [NI];
  logic          mem_read_s [NI];
  logic          mem_write_s[NI];
  logic [AW-1:0] mem_addr_s [NI];
  logic [BW-1:0] mem_wdata_s[NI];
  logic [BW-1:0] mem_rdata_s[NI];
  logic          mem_resp_s [NI];

  // Instance 0 uses round-robin, instance 1 fixed D-side priority
  for (genvar g = 0; g < NI; g++) begin : g_dut
    bmem_line_arbiter #(
      .BUS_WIDTH(BW), .BURST_LEN(BL), .ADDR_WIDTH(AW), .RR_EN((g == 0) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst),
      .i_read(i_read_s[g]), .i_addr(i_addr_s[g]), .i_rdata(i_rdata_s[g]), .i_resp(i_resp_s[g]),
      .d_read(d_read_s[g]), .d_write(d_write_s[g]), .d_addr(d_addr_s[g]),
      .d_wdata(d_wdata_s[g]), .d_rdata(d_rdata_s[g]), .d_resp(d_resp_s[g]),
      .mem_read(mem_read_s[g]), .mem_write(mem_write_s[g]), .mem_addr(mem_addr_s[g]),
      .mem_wdata(mem_wdata_s[g]), .mem_rdata(mem_rdata_s[g]), .mem_resp(mem_resp_s[g])
    );
  end

  // Transaction-level model state per instance
  bit            m_busy  [NI];
  bit            m_done  [NI];
  bit            m_wr    [NI];
  bit            m_port_d[NI];
  bit            m_pref_d[NI];
  logic [AW-1:0] m_addr  [NI];
  int            m_beats [NI];
  logic [LW-1:0] m_line  [NI];

  // Stimulus controls
  bit rnd_en[NI];
  bit hold_i[NI];
  bit hold_d[NI];
  int wr_pct[NI];

  // Observation logs for the instance under directed test
  int            log_g;
  int            resp_log[$];
  logic [BW-1:0] wbeat_log[$];
  logic [AW-1:0] waddr_log[$];
  logic [AW-1:0] last_raddr;
  logic [LW-1:0] cap_line;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [BW-1:0] mem_word(input logic [AW-1:0] a, input int k);
    return {a ^ 32'hCAFE_0000, 32'h0000_BEE0 + 32'(k)};
  endfunction

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & ~AW'(LW / 8 - 1);
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < int'(LW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit activity();
    bit a = 1'b0;
    for (int g = 0; g < NI; g++)
      a |= i_read_s[g] | d_read_s[g] | d_write_s[g] | m_busy[g] | m_done[g];
    return a;
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  task automatic check_outputs();
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("mem_read%0d", g),  LW'(mem_read_s[g]),  LW'(m_busy[g] && !m_wr[g]));
      chk($sformatf("mem_write%0d", g), LW'(mem_write_s[g]), LW'(m_busy[g] && m_wr[g]));
      chk($sformatf("i_resp%0d", g),    LW'(i_resp_s[g]),    LW'(m_done[g] && !m_port_d[g]));
      chk($sformatf("d_resp%0d", g),    LW'(d_resp_s[g]),    LW'(m_done[g] && m_port_d[g]));
      if (m_busy[g])
        chk($sformatf("mem_addr%0d", g), LW'(mem_addr_s[g]), LW'(m_addr[g]));
      if (m_busy[g] && m_wr[g])
        chk($sformatf("mem_wdata%0d", g), LW'(mem_wdata_s[g]),
            LW'(d_wdata_s[g][m_beats[g]*BW +: BW]));
      if (m_done[g] && !m_port_d[g])
        chk($sformatf("i_rdata%0d", g), i_rdata_s[g], m_line[g]);
      if (m_done[g] && m_port_d[g] && !m_wr[g])
        chk($sformatf("d_rdata%0d", g), d_rdata_s[g], m_line[g]);
      if (g == log_g) begin
        if (i_resp_s[g]) begin resp_log.push_back(0); cap_line = i_rdata_s[g]; end
        if (d_resp_s[g]) begin resp_log.push_back(1); cap_line = d_rdata_s[g]; end
        if (mem_read_s[g]) last_raddr = mem_addr_s[g];
      end
    end
  endtask

  task automatic chk_zero_all();
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst_mem_read%0d", g),  LW'(mem_read_s[g]),  '0);
      chk($sformatf("rst_mem_write%0d", g), LW'(mem_write_s[g]), '0);
      chk($sformatf("rst_mem_addr%0d", g),  LW'(mem_addr_s[g]),  '0);
      chk($sformatf("rst_mem_wdata%0d", g), LW'(mem_wdata_s[g]), '0);
      chk($sformatf("rst_i_resp%0d", g),    LW'(i_resp_s[g]),    '0);
      chk($sformatf("rst_d_resp%0d", g),    LW'(d_resp_s[g]),    '0);
      chk($sformatf("rst_i_rdata%0d", g),   i_rdata_s[g],        '0);
      chk($sformatf("rst_d_rdata%0d", g),   d_rdata_s[g],        '0);
    end
  endtask

  // Drive requesters and memory for the coming edge, then advance the model across it
  task automatic drive_and_model(input bit do_rst);
    bit pi, pd, gd, wr;
    if (do_rst) begin
      rst = 1'b0;
      for (int g = 0; g < NI; g++) begin
        i_read_s[g] = 1'b0; d_read_s[g] = 1'b0; d_write_s[g] = 1'b0;
        mem_resp_s[g] = 1'b0;
        m_busy[g] = 1'b0; m_done[g] = 1'b0; m_beats[g] = 0; m_pref_d[g] = 1'b1;
      end
      return;
    end
    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      if (!i_read_s[g] && (hold_i[g] || (rnd_en[g] && $urandom_range(0, 99) < 20))) begin
        i_read_s[g] = 1'b1;
        i_addr_s[g] = $urandom;
      end
      if (!d_read_s[g] && !d_write_s[g] &&
          (hold_d[g] || (rnd_en[g] && $urandom_range(0, 99) < 20))) begin
        wr = ($urandom_range(0, 99) < wr_pct[g]);
        d_write_s[g] = wr;
        d_read_s[g]  = !wr;
        d_addr_s[g]  = $urandom;
        d_wdata_s[g] = rand_line();
      end
      if (m_done[g] && !m_port_d[g]) i_read_s[g] = 1'b0;
      if (m_done[g] && m_port_d[g]) begin d_read_s[g] = 1'b0; d_write_s[g] = 1'b0; end

      if (m_busy[g] && $urandom_range(0, 99) < 55) begin
        mem_resp_s[g]  = 1'b1;
        mem_rdata_s[g] = m_wr[g] ? {$urandom, $urandom} : mem_word(m_addr[g], m_beats[g]);
        if (g == log_g && m_wr[g]) begin
          wbeat_log.push_back(mem_wdata_s[g]);
          waddr_log.push_back(mem_addr_s[g]);
        end
      end else begin
        mem_resp_s[g]  = 1'b0;
        mem_rdata_s[g] = {$urandom, $urandom};
      end

      if (m_done[g]) begin
        m_done[g] = 1'b0;
      end else if (!m_busy[g]) begin
        pi = i_read_s[g];
        pd = d_read_s[g] | d_write_s[g];
        if (pi || pd) begin
          gd = pd && (!pi || g != 0 || m_pref_d[g]);
          m_pref_d[g] = !gd;
          m_port_d[g] = gd;
          m_wr[g]     = gd && d_write_s[g];
          m_addr[g]   = align(gd ? d_addr_s[g] : i_addr_s[g]);
          m_busy[g]   = 1'b1;
          m_beats[g]  = 0;
          m_line[g]   = '0;
        end
      end else if (mem_resp_s[g]) begin
        if (!m_wr[g]) m_line[g][m_beats[g]*BW +: BW] = mem_word(m_addr[g], m_beats[g]);
        m_beats[g]++;
        if (m_beats[g] == int'(BL)) begin
          m_busy[g] = 1'b0;
          m_done[g] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit do_rst);
    check_outputs();
    drive_and_model(do_rst);
    @(negedge clk);
  endtask

  task automatic wait_resps(input int n, input string nm);
    int c = 0;
    while (resp_log.size() < n && c < 400) begin step(1'b0); c++; end
    n_chk++;
    if (resp_log.size() < n) begin
      n_fail++;
      $display("FAIL %s: got %0d responses expected %0d", nm, resp_log.size(), n);
    end
  endtask

  task automatic drain();
    int c = 0;
    for (int g = 0; g < NI; g++) begin rnd_en[g] = 1'b0; hold_i[g] = 1'b0; hold_d[g] = 1'b0; end
    while (activity() && c < 400) begin step(1'b0); c++; end
    n_chk++;
    if (activity()) begin
      n_fail++;
      $display("FAIL drain: activity pending after %0d cycles expected idle", c);
    end
  endtask

  task automatic clear_logs();
    resp_log.delete(); wbeat_log.delete(); waddr_log.delete();
    last_raddr = '0; cap_line = '0;
  endtask

  logic [BW-1:0] wlit [BL];
  logic [LW-1:0] exp_line;
  int            exp_ord [4];
  int            c5;

  initial begin
    log_g = 0;
    for (int g = 0; g < NI; g++) begin
      i_read_s[g] = 1'b0; i_addr_s[g] = '0; d_read_s[g] = 1'b0; d_write_s[g] = 1'b0;
      d_addr_s[g] = '0; d_wdata_s[g] = '0; mem_rdata_s[g] = '0; mem_resp_s[g] = 1'b0;
      rnd_en[g] = 1'b0; hold_i[g] = 1'b0; hold_d[g] = 1'b0; wr_pct[g] = 0;
    end
    clear_logs();
    drive_and_model(1'b1);
    @(negedge clk);
    chk_zero_all();

    // Round-robin under sustained contention: D first after reset, then alternate
    log_g = 0; clear_logs();
    hold_i[0] = 1'b1; hold_d[0] = 1'b1; wr_pct[0] = 0;
    wait_resps(4, "rr_rounds");
    hold_i[0] = 1'b0; hold_d[0] = 1'b0;
    exp_ord = '{1, 0, 1, 0};
    if (resp_log.size() >= 4)
      for (int k = 0; k < 4; k++) chk($sformatf("rr_order%0d", k), LW'(resp_log[k]), LW'(exp_ord[k]));
    drain();

    // Fixed priority: D re-requesting right after each resp starves I
    log_g = 1; clear_logs();
    hold_i[1] = 1'b1; hold_d[1] = 1'b1; wr_pct[1] = 0;
    wait_resps(3, "fp_d_rounds");
    hold_d[1] = 1'b0;
    wait_resps(4, "fp_i_round");
    hold_i[1] = 1'b0;
    exp_ord = '{1, 1, 1, 0};
    if (resp_log.size() >= 4)
      for (int k = 0; k < 4; k++) chk($sformatf("fp_order%0d", k), LW'(resp_log[k]), LW'(exp_ord[k]));
    drain();

    // Single I-side read of an unaligned address
    log_g = 0; clear_logs();
    i_read_s[0] = 1'b1; i_addr_s[0] = 32'h0000_1234;
    wait_resps(1, "t1_resp");
    exp_line = {64'hCAFE1220_0000BEE3, 64'hCAFE1220_0000BEE2,
                64'hCAFE1220_0000BEE1, 64'hCAFE1220_0000BEE0};
    chk("t1_model_line", m_line[0], exp_line);
    chk("t1_rdata", cap_line, exp_line);
    chk("t1_mem_addr", LW'(last_raddr), LW'(32'h0000_1220));
    if (resp_log.size() >= 1) chk("t1_port", LW'(resp_log[0]), LW'(0));
    drain();

    // Single D-side write: beats leave in order from the low end of the line
    log_g = 0; clear_logs();
    wlit = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
             64'h5555_AAAA_3333_CCCC, 64'h0F0F_0F0F_F0F0_F0F0};
    d_write_s[0] = 1'b1; d_read_s[0] = 1'b0; d_addr_s[0] = 32'h0000_0040;
    d_wdata_s[0] = {wlit[3], wlit[2], wlit[1], wlit[0]};
    wait_resps(1, "t2_resp");
    chk("t2_nbeats", LW'(wbeat_log.size()), LW'(BL));
    if (wbeat_log.size() == int'(BL))
      for (int k = 0; k < int'(BL); k++) begin
        chk($sformatf("t2_beat%0d", k), LW'(wbeat_log[k]), LW'(wlit[k]));
        chk($sformatf("t2_addr%0d", k), LW'(waddr_log[k]), LW'(32'h0000_0040));
      end
    if (resp_log.size() >= 1) chk("t2_port", LW'(resp_log[0]), LW'(1));
    drain();

    // Reset in the middle of a read burst, then a clean read
    log_g = 0; clear_logs();
    i_read_s[0] = 1'b1; i_addr_s[0] = 32'h0000_8000;
    c5 = 0;
    while (!(m_busy[0] && !m_wr[0] && m_beats[0] == 2) && c5 < 200) begin step(1'b0); c5++; end
    chk("t5_reach_beat2", LW'(m_beats[0]), LW'(2));
    step(1'b1);
    chk_zero_all();
    i_read_s[0] = 1'b1; i_addr_s[0] = 32'h0000_2468;
    wait_resps(1, "t5_resp");
    chk("t5_resp_count", LW'(resp_log.size()), LW'(1));
    exp_line = {64'hCAFE2460_0000BEE3, 64'hCAFE2460_0000BEE2,
                64'hCAFE2460_0000BEE1, 64'hCAFE2460_0000BEE0};
    chk("t5_rdata", cap_line, exp_line);
    drain();

    // Back-to-back D read then D write
    log_g = 0; clear_logs();
    d_read_s[0] = 1'b1; d_addr_s[0] = 32'h0001_0000;
    wait_resps(1, "t6_read");
    step(1'b0);
    d_write_s[0] = 1'b1; d_addr_s[0] = 32'h0002_0020; d_wdata_s[0] = rand_line();
    wait_resps(2, "t6_write");
    drain();

    // Randomized traffic on both instances
    log_g = -1;
    for (int g = 0; g < NI; g++) begin rnd_en[g] = 1'b1; wr_pct[g] = 50; end
    for (int n = 0; n < 4000; n++) step(1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
